// File: rtl/servo_ramp_pwm_pkg.sv
// Shared servo timing constants and helpers, also used by the controller's
// joystick-to-microsecond scaling.
package servo_pkg;

  localparam int unsigned SERVO_MIN_US    = 650;
  localparam int unsigned SERVO_MAX_US    = 2600;
  localparam int unsigned SERVO_CENTER_US = 1500;
  localparam int unsigned SERVO_FRAME_US  = 20000;
  localparam int unsigned US_W            = 12;

  // Clock cycles per microsecond; callers need an integer result of at least 2.
  function automatic int unsigned us_div(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/servo_ramp_pwm_us_tick_gen.sv
// Microsecond prescaler plus frame-position counter; shared by all servo
// channels so their frames stay phase-aligned.
module us_tick_gen
  import servo_pkg::*;
#(
  parameter  int unsigned DIV      = 25,
  parameter  int unsigned FRAME_US = SERVO_FRAME_US,
  localparam int unsigned PRE_W    = $clog2(DIV),
  localparam int unsigned CNT_W    = $clog2(FRAME_US)
) (
  input  logic             CLK,
  input  logic             RST_N,
  output logic             tick,
  output logic [CNT_W-1:0] us_cnt,
  output logic             frame_boundary
);

  logic [PRE_W-1:0] presc;

  assign tick           = (presc == PRE_W'(DIV - 1));
  assign frame_boundary = tick && (us_cnt == CNT_W'(FRAME_US - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (tick) begin
      presc  <= '0;
      us_cnt <= frame_boundary ? '0 : us_cnt + CNT_W'(1);
    end else begin
      presc  <= presc + PRE_W'(1);
    end
  end

endmodule

// File: rtl/servo_ramp_pwm.sv
// One servo channel: clamps and slew-limits the commanded pulse width once per
// frame and emits a 50 Hz PWM with full-width pulses only.
module servo_ramp_pwm
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned FRAME_US  = SERVO_FRAME_US,
  parameter int unsigned MIN_US    = SERVO_MIN_US,
  parameter int unsigned MAX_US    = SERVO_MAX_US,
  parameter int unsigned CENTER_US = SERVO_CENTER_US,
  parameter int unsigned STEP_US   = 20
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [31:0]     target_us,
  input  logic            enable,
  output logic            pwm,
  output logic [US_W-1:0] cur_us,
  output logic            frame_start,
  output logic            at_target
);

  localparam int unsigned DIV   = us_div(CLK_HZ);
  localparam int unsigned CNT_W = $clog2(FRAME_US);
  localparam int unsigned CMP_W = (CNT_W > US_W) ? CNT_W : US_W;

  logic             tick;
  logic             frame_boundary;
  logic [CNT_W-1:0] us_cnt;
  logic             en_frame;
  logic [US_W-1:0]  tgt_clamped;
  logic [US_W-1:0]  cur_next;

  // Range check on the full 32 bits so large commands cannot wrap into range.
  function automatic logic [US_W-1:0] clamp_us(input logic [31:0] t);
    if (t < MIN_US) return US_W'(MIN_US);
    if (t > MAX_US) return US_W'(MAX_US);
    return t[US_W-1:0];
  endfunction

  function automatic logic [US_W-1:0] slew_us(input logic [US_W-1:0] cur,
                                              input logic [US_W-1:0] tgt);
    logic [US_W-1:0] step;
    step = US_W'(STEP_US);
    if (STEP_US == 0) return tgt;
    if (tgt > cur) return ((tgt - cur) > step) ? cur + step : tgt;
    if (tgt < cur) return ((cur - tgt) > step) ? cur - step : tgt;
    return cur;
  endfunction

  assign tgt_clamped = clamp_us(target_us);
  assign cur_next    = enable ? slew_us(cur_us, tgt_clamped) : cur_us;

  us_tick_gen #(
    .DIV      (DIV),
    .FRAME_US (FRAME_US)
  ) u_tick (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .tick           (tick),
    .us_cnt         (us_cnt),
    .frame_boundary (frame_boundary)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cur_us      <= US_W'(CENTER_US);
      en_frame    <= 1'b0;
      pwm         <= 1'b0;
      frame_start <= 1'b0;
      at_target   <= 1'b0;
    end else begin
      frame_start <= frame_boundary;
      // en_frame only moves at a boundary, so a pulse in progress always completes.
      pwm         <= en_frame && (CMP_W'(us_cnt) < CMP_W'(cur_us));
      if (tick && frame_boundary) begin
        en_frame  <= enable;
        cur_us    <= cur_next;
        at_target <= (cur_next == tgt_clamped);
      end
    end
  end

endmodule

// File: tb/tb_servo_ramp_pwm.sv
// Directed bench for servo_ramp_pwm on a scaled-down timebase
// (DIV=2, 100 us frame, range 20..80, centre 50, step 7).
module tb_servo_ramp_pwm;

  localparam int unsigned CLK_HZ = 2_000_000;
  localparam int unsigned FRAME  = 100;
  localparam int unsigned MIN    = 20;
  localparam int unsigned MAX    = 80;
  localparam int unsigned CENTER = 50;
  localparam int unsigned STEP   = 7;
  localparam int          FLEN   = 200;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] target_us;
  logic [31:0] target_s0;
  logic        enable;
  logic        pwm, frame_start, at_target;
  logic [11:0] cur_us;
  logic        pwm_s0, fs_s0, at_s0;
  logic [11:0] cur_s0;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  servo_ramp_pwm #(
    .CLK_HZ(CLK_HZ), .FRAME_US(FRAME), .MIN_US(MIN), .MAX_US(MAX),
    .CENTER_US(CENTER), .STEP_US(STEP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .target_us(target_us), .enable(enable),
    .pwm(pwm), .cur_us(cur_us), .frame_start(frame_start), .at_target(at_target)
  );

  servo_ramp_pwm #(
    .CLK_HZ(CLK_HZ), .FRAME_US(FRAME), .MIN_US(MIN), .MAX_US(MAX),
    .CENTER_US(CENTER), .STEP_US(0)
  ) dut_s0 (
    .CLK(CLK), .RST_N(RST_N), .target_us(target_s0), .enable(enable),
    .pwm(pwm_s0), .cur_us(cur_s0), .frame_start(fs_s0), .at_target(at_s0)
  );

  // Runs from the current negedge until the next frame_start (bounded),
  // counting high cycles of both PWM outputs.
  task automatic run_frame(output int hi, output int hi0, output int len);
    hi = 0; hi0 = 0; len = 0;
    do begin
      hi  += int'(pwm);
      hi0 += int'(pwm_s0);
      @(negedge CLK);
      len++;
    end while (!frame_start && len < 1000);
  endtask

  task automatic test_reset();
    int hi, hi0, len;
    RST_N = 1'b0; enable = 1'b1; target_us = 32'd50; target_s0 = 32'd50;
    repeat (3) @(negedge CLK);
    n_vec++; if (pwm !== 1'b0) begin n_err++; $display("FAIL reset_pwm: got %b want 0", pwm); end
    n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    n_vec++; if (cur_us !== 12'd50) begin n_err++; $display("FAIL reset_cur: got %0d want 50", cur_us); end
    n_vec++; if (at_target !== 1'b0) begin n_err++; $display("FAIL reset_at: got %b want 0", at_target); end
    RST_N = 1'b1;
    run_frame(hi, hi0, len);
    n_vec++; if (len !== FLEN) begin n_err++; $display("FAIL first_boundary_len: got %0d want %0d", len, FLEN); end
    n_vec++; if (hi !== 0) begin n_err++; $display("FAIL first_frame_nopulse: got %0d want 0", hi); end
  endtask

  task automatic test_hold_center();
    int hi, hi0, len;
    n_vec++; if (cur_us !== 12'd50) begin n_err++; $display("FAIL hold_cur0: got %0d want 50", cur_us); end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL hold_at0: got %b want 1", at_target); end
    for (int i = 0; i < 2; i++) begin
      run_frame(hi, hi0, len);
      n_vec++; if (hi !== 100) begin n_err++; $display("FAIL hold_hi[%0d]: got %0d want 100", i, hi); end
      n_vec++; if (len !== FLEN) begin n_err++; $display("FAIL hold_len[%0d]: got %0d want %0d", i, len, FLEN); end
      n_vec++; if (cur_us !== 12'd50 || at_target !== 1'b1) begin
        n_err++; $display("FAIL hold_state[%0d]: got cur=%0d at=%b want cur=50 at=1", i, cur_us, at_target);
      end
    end
  endtask

  task automatic test_ramp();
    int hi, hi0, len;
    int up[5] = '{57, 64, 71, 78, 80};
    int dn[5] = '{73, 66, 59, 52, 50};
    int prev;
    prev = 50;
    target_us = 32'd80;
    for (int i = 0; i < 5; i++) begin
      run_frame(hi, hi0, len);
      n_vec++; if (hi !== 2 * prev) begin n_err++; $display("FAIL ramp_up_hi[%0d]: got %0d want %0d", i, hi, 2 * prev); end
      n_vec++; if (cur_us !== 12'(up[i])) begin n_err++; $display("FAIL ramp_up_cur[%0d]: got %0d want %0d", i, cur_us, up[i]); end
      n_vec++; if (at_target !== (i == 4)) begin n_err++; $display("FAIL ramp_up_at[%0d]: got %b want %b", i, at_target, (i == 4)); end
      prev = up[i];
    end
    target_us = 32'd50;
    for (int i = 0; i < 5; i++) begin
      run_frame(hi, hi0, len);
      n_vec++; if (hi !== 2 * prev) begin n_err++; $display("FAIL ramp_dn_hi[%0d]: got %0d want %0d", i, hi, 2 * prev); end
      n_vec++; if (cur_us !== 12'(dn[i])) begin n_err++; $display("FAIL ramp_dn_cur[%0d]: got %0d want %0d", i, cur_us, dn[i]); end
      n_vec++; if (at_target !== (i == 4)) begin n_err++; $display("FAIL ramp_dn_at[%0d]: got %b want %b", i, at_target, (i == 4)); end
      prev = dn[i];
    end
  endtask

  task automatic test_clamp();
    int hi, hi0, len;
    int up[5] = '{57, 64, 71, 78, 80};
    int dn[9] = '{73, 66, 59, 52, 45, 38, 31, 24, 20};
    target_us = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      run_frame(hi, hi0, len);
      n_vec++; if (cur_us !== 12'(up[i])) begin n_err++; $display("FAIL clamp_hi_cur[%0d]: got %0d want %0d", i, cur_us, up[i]); end
    end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL clamp_hi_at: got %b want 1", at_target); end
    // Low 12 bits read as 50, which must not be mistaken for an in-range command.
    target_us = 32'h0000_1032;
    run_frame(hi, hi0, len);
    n_vec++; if (hi !== 160) begin n_err++; $display("FAIL clamp_max_hi: got %0d want 160", hi); end
    n_vec++; if (cur_us !== 12'd80 || at_target !== 1'b1) begin
      n_err++; $display("FAIL clamp_nowrap: got cur=%0d at=%b want cur=80 at=1", cur_us, at_target);
    end
    target_us = 32'd0;
    for (int i = 0; i < 9; i++) begin
      run_frame(hi, hi0, len);
      n_vec++; if (cur_us !== 12'(dn[i])) begin n_err++; $display("FAIL clamp_lo_cur[%0d]: got %0d want %0d", i, cur_us, dn[i]); end
      n_vec++; if (at_target !== (i == 8)) begin n_err++; $display("FAIL clamp_lo_at[%0d]: got %b want %b", i, at_target, (i == 8)); end
    end
    target_us = 32'd21;
    run_frame(hi, hi0, len);
    n_vec++; if (cur_us !== 12'd21 || at_target !== 1'b1) begin
      n_err++; $display("FAIL residual_one: got cur=%0d at=%b want cur=21 at=1", cur_us, at_target);
    end
  endtask

  task automatic test_step0();
    int hi, hi0, len;
    target_s0 = 32'd75;
    run_frame(hi, hi0, len);
    n_vec++; if (cur_s0 !== 12'd75 || at_s0 !== 1'b1) begin
      n_err++; $display("FAIL step0_jump: got cur=%0d at=%b want cur=75 at=1", cur_s0, at_s0);
    end
    n_vec++; if (fs_s0 !== 1'b1) begin n_err++; $display("FAIL step0_fs: got %b want 1", fs_s0); end
    target_s0 = 32'hFFFF_FFFF;
    run_frame(hi, hi0, len);
    n_vec++; if (hi0 !== 150) begin n_err++; $display("FAIL step0_hi: got %0d want 150", hi0); end
    n_vec++; if (cur_s0 !== 12'd80) begin n_err++; $display("FAIL step0_clamp: got %0d want 80", cur_s0); end
  endtask

  task automatic test_enable_mid();
    int hi, hi0, len;
    bit  mid_pwm;
    hi = 0; len = 0; mid_pwm = 1'b0;
    do begin
      if (len == 10) begin
        mid_pwm = pwm;
        enable = 1'b0;
        target_us = 32'd60;
      end
      hi += int'(pwm);
      @(negedge CLK);
      len++;
    end while (!frame_start && len < 1000);
    n_vec++; if (mid_pwm !== 1'b1) begin n_err++; $display("FAIL en_mid_pwm: got %b want 1", mid_pwm); end
    n_vec++; if (hi !== 42) begin n_err++; $display("FAIL en_pulse_completes: got %0d want 42", hi); end
    n_vec++; if (cur_us !== 12'd21 || at_target !== 1'b0) begin
      n_err++; $display("FAIL en_hold: got cur=%0d at=%b want cur=21 at=0", cur_us, at_target);
    end
    enable = 1'b1;
    run_frame(hi, hi0, len);
    n_vec++; if (hi !== 0) begin n_err++; $display("FAIL en_off_frame: got %0d want 0", hi); end
    n_vec++; if (cur_us !== 12'd28 || at_target !== 1'b0) begin
      n_err++; $display("FAIL en_resume: got cur=%0d at=%b want cur=28 at=0", cur_us, at_target);
    end
  endtask

  task automatic test_midframe_target();
    int hi, len;
    hi = 0; len = 0;
    do begin
      if (len == 140) target_us = 32'd20;
      if (len == 190) target_us = 32'd28;
      hi += int'(pwm);
      @(negedge CLK);
      len++;
    end while (!frame_start && len < 1000);
    n_vec++; if (hi !== 56) begin n_err++; $display("FAIL en_rise_pulse: got %0d want 56", hi); end
    n_vec++; if (len !== FLEN) begin n_err++; $display("FAIL midtgt_len: got %0d want %0d", len, FLEN); end
    n_vec++; if (cur_us !== 12'd28 || at_target !== 1'b1) begin
      n_err++; $display("FAIL midtgt_ignored: got cur=%0d at=%b want cur=28 at=1", cur_us, at_target);
    end
  endtask

  task automatic test_reset_mid();
    int hi, hi0, len;
    repeat (20) @(negedge CLK);
    n_vec++; if (pwm !== 1'b1) begin n_err++; $display("FAIL rstmid_prepwm: got %b want 1", pwm); end
    RST_N = 1'b0;
    @(negedge CLK);
    n_vec++; if (pwm !== 1'b0) begin n_err++; $display("FAIL rstmid_pwm: got %b want 0", pwm); end
    n_vec++; if (cur_us !== 12'd50 || at_target !== 1'b0) begin
      n_err++; $display("FAIL rstmid_state: got cur=%0d at=%b want cur=50 at=0", cur_us, at_target);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    run_frame(hi, hi0, len);
    n_vec++; if (hi !== 0) begin n_err++; $display("FAIL rstmid_nopulse: got %0d want 0", hi); end
    n_vec++; if (len !== FLEN) begin n_err++; $display("FAIL rstmid_len: got %0d want %0d", len, FLEN); end
    n_vec++; if (cur_us !== 12'd43 || at_target !== 1'b0) begin
      n_err++; $display("FAIL rstmid_restart: got cur=%0d at=%b want cur=43 at=0", cur_us, at_target);
    end
  endtask

  initial begin
    test_reset();
    test_hold_center();
    test_ramp();
    test_clamp();
    test_step0();
    test_enable_mid();
    test_midframe_target();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
